stop_it_ctrl: RTL and testbench

Game controller for the Stop-It game. It sits directly downstream of the 5-bit LFSR: it drives the LFSR's advance request and latches the LFSR output as the round target. It then runs a free-counting value that the player must stop exactly on the target. It reports win/lose, the live count and a win streak to the display logic.

---
 rtl/stop_it_ctrl.sv | 159 +++++++++++++++
 tb/tb_stop_it_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stop_it_ctrl.sv
// Stop-It game controller: captures the LFSR value as a round target, runs a
// free count the player must stop on that target, and reports result/streak.
module stop_it_ctrl #(
    parameter int unsigned SHOW_TICKS   = 4,
    parameter int unsigned RESULT_TICKS = 8,
    parameter int unsigned MAX_LAPS     = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [4:0] rand_i,
    output logic       rand_next_o,
    output logic [4:0] target_o,
    output logic [4:0] count_o,
    output logic [2:0] phase_o,
    output logic       win_o,
    output logic       lose_o,
    output logic [3:0] score_o
);

    localparam int unsigned VAL_W     = 5;
    localparam int unsigned SCORE_W   = 4;
    localparam int unsigned TICK_MAX  = (SHOW_TICKS > RESULT_TICKS) ? SHOW_TICKS : RESULT_TICKS;
    localparam int unsigned TICK_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int unsigned LAP_W     = (MAX_LAPS > 1) ? $clog2(MAX_LAPS) : 1;
    localparam int unsigned COUNT_TOP = (1 << VAL_W) - 1;
    localparam int unsigned SCORE_TOP = (1 << SCORE_W) - 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW  = 3'd1,
        COUNT = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } phase_t;

    phase_t              phase,    phase_nxt;
    logic [VAL_W-1:0]    target,   target_nxt;
    logic [VAL_W-1:0]    count,    count_nxt;
    logic [SCORE_W-1:0]  score,    score_nxt;
    logic [TICK_W-1:0]   tick_cnt, tick_cnt_nxt;
    logic [LAP_W-1:0]    lap_cnt,  lap_cnt_nxt;
    logic                start_q;
    logic                stop_q;
    logic                start_rise;
    logic                stop_rise;

    assign start_rise = start_i & ~start_q;
    assign stop_rise  = stop_i  & ~stop_q;

    // State and datapath registers; edge-detect flops track the buttons in every phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase    <= IDLE;
            target   <= '0;
            count    <= '0;
            score    <= '0;
            tick_cnt <= '0;
            lap_cnt  <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            target   <= target_nxt;
            count    <= count_nxt;
            score    <= score_nxt;
            tick_cnt <= tick_cnt_nxt;
            lap_cnt  <= lap_cnt_nxt;
            start_q  <= start_i;
            stop_q   <= stop_i;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        phase_nxt    = phase;
        target_nxt   = target;
        count_nxt    = count;
        score_nxt    = score;
        tick_cnt_nxt = tick_cnt;
        lap_cnt_nxt  = lap_cnt;

        unique case (phase)
            IDLE: begin
                if (start_rise) begin
                    target_nxt   = rand_i;
                    count_nxt    = '0;
                    tick_cnt_nxt = '0;
                    lap_cnt_nxt  = '0;
                    phase_nxt    = SHOW;
                end
            end

            SHOW: begin
                if (tick_i) begin
                    if (tick_cnt == TICK_W'(SHOW_TICKS - 1)) begin
                        tick_cnt_nxt = '0;
                        phase_nxt    = COUNT;
                    end else begin
                        tick_cnt_nxt = tick_cnt + TICK_W'(1);
                    end
                end
            end

            COUNT: begin
                // A stop press freezes the count and judges the pre-increment value.
                if (stop_rise) begin
                    if (count == target) begin
                        phase_nxt = WIN;
                        score_nxt = (score == SCORE_W'(SCORE_TOP)) ? score
                                                                   : score + SCORE_W'(1);
                    end else begin
                        phase_nxt = LOSE;
                        score_nxt = '0;
                    end
                end else if (tick_i) begin
                    count_nxt = count + VAL_W'(1);
                    if (count == VAL_W'(COUNT_TOP)) begin
                        if (lap_cnt == LAP_W'(MAX_LAPS - 1)) begin
                            phase_nxt = LOSE;
                            score_nxt = '0;
                        end else begin
                            lap_cnt_nxt = lap_cnt + LAP_W'(1);
                        end
                    end
                end
            end

            WIN, LOSE: begin
                if (tick_i) begin
                    if (tick_cnt == TICK_W'(RESULT_TICKS - 1)) begin
                        tick_cnt_nxt = '0;
                        phase_nxt    = IDLE;
                    end else begin
                        tick_cnt_nxt = tick_cnt + TICK_W'(1);
                    end
                end
            end

            default: begin
                phase_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        rand_next_o = (phase == IDLE);
        win_o       = (phase == WIN);
        lose_o      = (phase == LOSE);
        phase_o     = phase;
        target_o    = target;
        count_o     = count;
        score_o     = score;
    end

endmodule

// File: tb/tb_stop_it_ctrl.sv
// Directed bench for stop_it_ctrl with hand-computed expectations.
module tb_stop_it_ctrl;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       tick_i;
    logic       start_i;
    logic       stop_i;
    logic [4:0] rand_i;
    logic       rand_next_o;
    logic [4:0] target_o;
    logic [4:0] count_o;
    logic [2:0] phase_o;
    logic       win_o;
    logic       lose_o;
    logic [3:0] score_o;

    int total = 0;
    int bad   = 0;

    stop_it_ctrl #(
        .SHOW_TICKS  (4),
        .RESULT_TICKS(8),
        .MAX_LAPS    (2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .tick_i     (tick_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .rand_i     (rand_i),
        .rand_next_o(rand_next_o),
        .target_o   (target_o),
        .count_o    (count_o),
        .phase_o    (phase_o),
        .win_o      (win_o),
        .lose_o     (lose_o),
        .score_o    (score_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges; sampling/driving happens 1 time unit after each edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_i = 1'b1;
            cyc(1);
            tick_i = 1'b0;
        end
    endtask

    task automatic press_start();
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    task automatic press_stop();
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
    endtask

    // Start a round with target tgt, show it, count up to stop_at, press stop.
    task automatic play(input logic [4:0] tgt, input int stop_at);
        rand_i = tgt;
        press_start();
        tick(4);
        tick(stop_at);
        press_stop();
    endtask

    initial begin
        rst_i   = 1'b1;
        tick_i  = 1'b0;
        start_i = 1'b1;
        stop_i  = 1'b0;
        rand_i  = 5'd0;
        #1;

        // Reset values with start held through reset
        cyc(2);
        check("rst_phase",  8'(phase_o),     8'd0);
        check("rst_target", 8'(target_o),    8'd0);
        check("rst_count",  8'(count_o),     8'd0);
        check("rst_score",  8'(score_o),     8'd0);
        check("rst_rnext",  8'(rand_next_o), 8'd1);
        check("rst_win",    8'(win_o),       8'd0);
        check("rst_lose",   8'(lose_o),      8'd0);
        rst_i = 1'b0;
        cyc(1);
        check("held_start_rise", 8'(phase_o), 8'd1);

        // Return to a clean idle
        start_i = 1'b0;
        rst_i   = 1'b1;
        cyc(2);
        rst_i   = 1'b0;
        cyc(1);
        check("idle_again", 8'(phase_o), 8'd0);

        // Target capture and show duration
        rand_i = 5'd13;
        press_start();
        check("cap_phase",  8'(phase_o),     8'd1);
        check("cap_target", 8'(target_o),    8'd13);
        check("cap_rnext",  8'(rand_next_o), 8'd0);
        tick(3);
        check("show_3ticks", 8'(phase_o), 8'd1);
        tick(1);
        check("show_done_phase", 8'(phase_o), 8'd2);
        check("show_done_count", 8'(count_o), 8'd0);

        // First win
        tick(13);
        check("cnt13", 8'(count_o), 8'd13);
        press_stop();
        check("win_phase", 8'(phase_o), 8'd3);
        check("win_flag",  8'(win_o),   8'd1);
        check("win_score", 8'(score_o), 8'd1);
        tick(7);
        check("win_hold", 8'(phase_o), 8'd3);
        tick(1);
        check("win_end_phase", 8'(phase_o),     8'd0);
        check("win_end_score", 8'(score_o),     8'd1);
        check("win_end_rnext", 8'(rand_next_o), 8'd1);
        check("win_end_target", 8'(target_o),   8'd13);

        // Fifteen more wins: streak saturates at 15
        for (int i = 0; i < 15; i++) begin
            play(5'd13, 13);
            if (i == 13) check("score_15", 8'(score_o), 8'd15);
            tick(8);
        end
        check("score_sat", 8'(score_o), 8'd15);

        // Lose at count 12
        play(5'd13, 12);
        check("lose_phase", 8'(phase_o), 8'd4);
        check("lose_flag",  8'(lose_o),  8'd1);
        check("lose_win",   8'(win_o),   8'd0);
        check("lose_score", 8'(score_o), 8'd0);
        tick(8);
        check("lose_end", 8'(phase_o), 8'd0);

        // Stop and tick together at count 13: win, count frozen
        rand_i = 5'd13;
        press_start();
        tick(4);
        tick(13);
        stop_i = 1'b1;
        tick_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
        tick_i = 1'b0;
        check("simul_phase", 8'(phase_o), 8'd3);
        check("simul_count", 8'(count_o), 8'd13);
        check("simul_score", 8'(score_o), 8'd1);
        tick(8);

        // Timeout with stop held from SHOW into COUNT
        rand_i = 5'd5;
        press_start();
        tick(2);
        stop_i = 1'b1;
        cyc(1);
        tick(2);
        check("to_enter", 8'(phase_o), 8'd2);
        tick(31);
        check("to_c31_phase", 8'(phase_o), 8'd2);
        check("to_c31_count", 8'(count_o), 8'd31);
        tick(1);
        check("to_wrap_phase", 8'(phase_o), 8'd2);
        check("to_wrap_count", 8'(count_o), 8'd0);
        stop_i = 1'b0;
        tick(31);
        check("to_lap2_phase", 8'(phase_o), 8'd2);
        tick(1);
        check("to_lose_phase", 8'(phase_o), 8'd4);
        check("to_lose_count", 8'(count_o), 8'd0);
        check("to_lose_score", 8'(score_o), 8'd0);
        tick(8);

        // Fresh stop press after a held-stop round still works; build streak of 3
        play(5'd20, 20);
        play_tail();
        play(5'd3, 3);
        play_tail();
        play(5'd0, 0);
        check("zero_target_win", 8'(phase_o), 8'd3);
        tick(8);
        check("streak3", 8'(score_o), 8'd3);

        // Reset mid-round at count 7
        rand_i = 5'd9;
        press_start();
        tick(4);
        start_i = 1'b1;
        tick(7);
        start_i = 1'b0;
        check("mid_count", 8'(count_o), 8'd7);
        check("mid_phase_start_ignored", 8'(phase_o), 8'd2);
        rst_i = 1'b1;
        cyc(1);
        rst_i = 1'b0;
        check("mr_phase",  8'(phase_o),  8'd0);
        check("mr_count",  8'(count_o),  8'd0);
        check("mr_score",  8'(score_o),  8'd0);
        check("mr_target", 8'(target_o), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic play_tail();
        check("tail_win", 8'(win_o), 8'd1);
        tick(8);
    endtask

endmodule
